// File: rtl/serial_to_parallel_pkg.sv
// Shared constants and state encoding for the MRAM serial link
// (serialiser and deserialiser).
package serial_to_parallel_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } s2p_state_e;

endpackage

// File: rtl/serial_to_parallel.sv
// Deserialiser: framed MSB-first bit stream -> DATA_W-bit words,
// with a one-cycle valid strobe and sticky framing/overrun flags.
module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rx_start,
    input  logic              rx_valid,
    input  logic              data_in,
    input  logic              word_ack,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    s2p_state_e        state_q, state_d;
    // Only the low DATA_W-1 bits are ever kept; the final bit goes
    // straight into the output word.
    logic [DATA_W-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic              pend_q, pend_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    logic [DATA_W-1:0] word;
    logic              ferr_set;
    logic              ovr_set;
    logic              done;

    assign word = {shift_q, data_in};

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        valid_d  = valid_q;
        pend_d   = pend_q;
        ferr_d   = ferr_q;
        ovr_d    = ovr_q;
        ferr_set = 1'b0;
        ovr_set  = 1'b0;
        done     = 1'b0;
        if (en) begin
            valid_d = 1'b0;
            if (rx_start) begin
                ferr_set = (state_q == ST_SHIFT);
                state_d  = ST_SHIFT;
                shift_d  = rx_valid ? (DATA_W-1)'(data_in) : '0;
                cnt_d    = rx_valid ? CNT_W'(1) : '0;
            end else if (state_q == ST_SHIFT && rx_valid) begin
                if (cnt_q == LAST) begin
                    done    = 1'b1;
                    out_d   = word;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    shift_d = word[DATA_W-2:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            // A completion wins over a same-cycle ack: the new word
            // is pending, and the ack only spares it an overrun.
            if (done) begin
                ovr_set = pend_q & ~word_ack;
                pend_d  = 1'b1;
            end else if (word_ack) begin
                pend_d  = 1'b0;
            end
            ferr_d = ferr_set | (ferr_q & ~err_clr);
            ovr_d  = ovr_set | (ovr_q & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // A strobe that lands in a frozen cycle is held until en returns.
    assign data_valid = valid_q & en;
    assign data_out   = out_q;
    assign busy       = (state_q == ST_SHIFT);
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: directed scenarios
// plus a randomized loopback against a bit-queue reference model.
module tb_serial_to_parallel;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          rx_start = 1'b0;
    logic          rx_valid = 1'b0;
    logic          data_in = 1'b0;
    logic          word_ack = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          busy;
    logic          frame_err;
    logic          overrun;

    serial_to_parallel dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rx_start   (rx_start),
        .rx_valid   (rx_valid),
        .data_in    (data_in),
        .word_ack   (word_ack),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int vcnt     = 0;
    int bcnt     = 0;
    int lb_cnt   = 0;
    bit chk_on   = 0;
    bit lb_on    = 0;
    logic [DW-1:0] lb_q[$];

    // Reference model: a frame is just the list of bits seen so far.
    bit          m_busy = 0;
    bit          bits[$];
    logic [DW-1:0] m_out = '0;
    bit          m_vpend = 0;
    bit          m_pend = 0;
    bit          m_ferr = 0;
    bit          m_ovr = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step(bit r, bit e, bit s, bit v,
                                       bit d, bit a, bit c);
        bit fe;
        bit oe;
        bit done;
        int w;
        if (r) begin
            m_busy = 0; bits.delete(); m_out = '0;
            m_vpend = 0; m_pend = 0; m_ferr = 0; m_ovr = 0;
            return;
        end
        if (!e) return;
        fe = 0; oe = 0; done = 0;
        if (s) begin
            fe = m_busy;
            m_busy = 1;
            bits.delete();
            if (v) bits.push_back(d);
        end else if (m_busy && v) begin
            bits.push_back(d);
            if (bits.size() == DW) done = 1;
        end
        if (done) begin
            w = 0;
            foreach (bits[i]) w = w * 2 + int'(bits[i]);
            m_out = w[DW-1:0];
            bits.delete();
            m_busy = 0;
            oe = m_pend && !a;
            m_pend = 1;
        end else if (a) begin
            m_pend = 0;
        end
        m_vpend = done;
        m_ferr = fe | (m_ferr & !c);
        m_ovr  = oe | (m_ovr & !c);
    endfunction

    task automatic cyc(input logic s, input logic v, input logic d,
                       input logic a = 1'b0, input logic c = 1'b0,
                       input logic e = 1'b1, input logic r = 1'b0);
        @(negedge clk);
        rst = r; en = e; rx_start = s; rx_valid = v;
        data_in = d; word_ack = a; err_clr = c;
        #1;
        if (chk_on) begin
            chk("busy", busy, m_busy);
            chk("data_out", data_out, m_out);
            chk("data_valid", data_valid, m_vpend & e);
            chk("frame_err", frame_err, m_ferr);
            chk("overrun", overrun, m_ovr);
        end
        if (data_valid) vcnt++;
        if (busy) bcnt++;
        if (lb_on && data_valid) begin
            chk("lb_word_expected", lb_q.size() > 0, 1);
            if (lb_q.size() > 0) chk("lb_word", data_out, lb_q.pop_front());
            lb_cnt++;
        end
        @(posedge clk);
        model_step(r, e, s, v, d, a, c);
    endtask

    task automatic send_frame(input logic [DW-1:0] w,
                              input logic ack_last = 1'b0);
        for (int i = 0; i < DW; i++)
            cyc(i == 0, 1'b1, w[DW-1-i], ack_last && i == DW - 1);
    endtask

    int v0;
    int b0;
    logic [DW-1:0] rw;

    initial begin
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk_on = 1;
        cyc(0, 0, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", busy, 0);

        // Basic frame
        v0 = vcnt; b0 = bcnt;
        send_frame(16'hA5C3);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("basic_pulses", vcnt - v0, 1);
        chk("basic_busy_cycles", bcnt - b0, 15);
        chk("basic_data", data_out, 16'hA5C3);
        chk("basic_ferr", frame_err, 0);
        chk("basic_ovr", overrun, 0);

        // Gapped frame with frozen cycles, then a deferred pulse
        cyc(0, 0, 0, 1);
        v0 = vcnt;
        rw = 16'h8001;
        for (int i = 0; i < DW; i++) begin
            cyc(i == 0, 1, rw[DW-1-i]);
            if (i == 7) repeat (3) cyc(0, 0, 0);
            if (i == 11) repeat (2) cyc(0, 1, 1, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("gap_no_pulse_frozen", vcnt - v0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0);
        chk("gap_pulses", vcnt - v0, 1);
        chk("gap_data", data_out, 16'h8001);

        // Resync
        for (int i = 0; i < 5; i++) cyc(i == 0, 1, 1);
        send_frame(16'h1234);
        cyc(0, 0, 0, 1);
        chk("resync_ferr", frame_err, 1);
        chk("resync_data", data_out, 16'h1234);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0);
        chk("resync_clr", frame_err, 0);

        // Overrun, then the same with ack on the completion cycle
        send_frame(16'h1111);
        send_frame(16'h2222);
        cyc(0, 0, 0);
        chk("ovr_set", overrun, 1);
        chk("ovr_data", data_out, 16'h2222);
        cyc(0, 0, 0, 1, 1);
        send_frame(16'h1111);
        send_frame(16'h2222, 1'b1);
        cyc(0, 0, 0, 1);
        chk("ovr_acked", overrun, 0);
        chk("ovr_acked_data", data_out, 16'h2222);

        // Reset mid-frame
        v0 = vcnt;
        for (int i = 0; i < 8; i++) cyc(i == 0, 1, 1);
        cyc(0, 1, 1, 0, 0, 1, 1);
        cyc(0, 0, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ferr", frame_err, 0);
        send_frame(16'hFFFF);
        cyc(0, 0, 0);
        chk("mid_rst_pulses", vcnt - v0, 1);
        chk("mid_rst_word", data_out, 16'hFFFF);

        // Randomized loopback
        lb_on = 1;
        for (int n = 0; n < 100; n++) begin
            rw = DW'($urandom);
            lb_q.push_back(rw);
            if ($urandom_range(0, 3) == 0)
                cyc(0, 1, 1'($urandom), 1'($urandom));
            for (int i = 0; i < DW; i++) begin
                while ($urandom_range(0, 7) == 0)
                    cyc(0, 0, 0, 1'($urandom), 0,
                        1'($urandom_range(0, 1)));
                cyc(i == 0, 1, rw[DW-1-i], 1'($urandom));
            end
        end
        repeat (3) cyc(0, 0, 0);
        lb_on = 0;
        chk("lb_count", lb_cnt, 100);
        chk("lb_drained", lb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
